// File: rtl/lstm_act_scheduler.sv
// rtl/lstm_act_scheduler.sv - shared sigmoid/tanh activation scheduler for LSTM gates

// Piecewise-linear sigmoid in Q6.11; odd symmetry around 0.5 handles negative x.
module sigmoid_q6_11 #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] ax;
  logic [WIDTH-1:0] pos;

  // Magnitude, segment select, then mirror for negative inputs.
  always_comb begin
    ax = x[WIDTH-1] ? (~x + 1'b1) : x;
    if (ax >= WIDTH'(10240))
      pos = WIDTH'(2048);
    else if (ax >= WIDTH'(4864))
      pos = (ax >> 5) + WIDTH'(1728);
    else if (ax >= WIDTH'(2048))
      pos = (ax >> 3) + WIDTH'(1280);
    else
      pos = (ax >> 2) + WIDTH'(1024);
    y = x[WIDTH-1] ? (WIDTH'(2048) - pos) : pos;
  end
endmodule

// tanh(x) = 2*sigmoid(2x) - 1; doubling saturates, which is harmless since
// the sigmoid is already flat well before the saturation point.
module tanh_q6_11 #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] x2;
  logic [WIDTH-1:0] s;

  // Saturating doubling of the input.
  always_comb begin
    if (x[WIDTH-1] != x[WIDTH-2])
      x2 = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      x2 = {x[WIDTH-2:0], 1'b0};
  end

  sigmoid_q6_11 #(.WIDTH(WIDTH)) u_sig (.x(x2), .y(s));

  assign y = (s << 1) - WIDTH'(2048);
endmodule

// Round-robin arbiter feeding a 2-stage activation pipeline with backpressure.
module lstm_act_scheduler #(
  parameter int WIDTH = 18,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_func,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_func,
  output logic                  busy,
  output logic [15:0]           done_cnt
);
  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_x, s2_y;
  logic [IDW-1:0]   s1_id, s2_id;
  logic             s1_func, s2_func;
  logic [IDW-1:0]   ptr, ptr_nxt;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gid, arb_j;
  logic             found;
  logic             adv1, adv2, accept;
  logic [WIDTH-1:0] gx, sig_y, tanh_y, y_sel;
  logic             gfunc;

  assign adv2 = !s2_valid | out_ready;
  assign adv1 = !s1_valid | adv2;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    arb_j = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_j = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req_valid[arb_j]) begin
        found        = 1'b1;
        grant[arb_j] = 1'b1;
        gid          = arb_j;
      end
    end
  end

  assign ptr_nxt   = IDW'((int'(gid) + 1) % NREQ);
  assign accept    = found & adv1 & !flush & !rst;
  assign req_ready = accept ? grant : '0;
  assign gx        = req_data[gid*WIDTH +: WIDTH];
  assign gfunc     = req_func[gid];

  sigmoid_q6_11 #(.WIDTH(WIDTH)) u_sigmoid (.x(s1_x), .y(sig_y));
  tanh_q6_11    #(.WIDTH(WIDTH)) u_tanh    (.x(s1_x), .y(tanh_y));

  assign y_sel = s1_func ? tanh_y : sig_y;

  // Pipeline stages, grant pointer and transfer counter; flush clears only valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_id    <= '0;
      s1_func  <= 1'b0;
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_id    <= '0;
      s2_func  <= 1'b0;
      ptr      <= '0;
      done_cnt <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_valid && out_ready)
        done_cnt <= done_cnt + 16'd1;
      if (adv2) begin
        s2_valid <= s1_valid;
        s2_y     <= y_sel;
        s2_id    <= s1_id;
        s2_func  <= s1_func;
      end
      if (adv1) begin
        s1_valid <= accept;
        if (accept) begin
          s1_x    <= gx;
          s1_id   <= gid;
          s1_func <= gfunc;
          ptr     <= ptr_nxt;
        end
      end
    end
  end

  // Outputs are forced to zero while reset is held, before the first edge lands.
  assign out_valid = s2_valid & !rst;
  assign out_data  = rst ? '0 : s2_y;
  assign out_id    = rst ? '0 : s2_id;
  assign out_func  = rst ? 1'b0 : s2_func;
  assign busy      = (s1_valid | s2_valid) & !rst;
endmodule

// File: tb/tb_lstm_act_scheduler.sv
// tb/tb_lstm_act_scheduler.sv - scoreboard bench for lstm_act_scheduler
module tb_lstm_act_scheduler;
  localparam int W = 18;
  localparam int N = 4;

  logic          clk, rst, flush, out_ready;
  logic [N-1:0]  req_valid, req_func, req_ready;
  logic [N*W-1:0] req_data;
  logic          out_valid, out_func, busy;
  logic [W-1:0]  out_data;
  logic [1:0]    out_id;
  logic [15:0]   done_cnt;

  logic [W-1:0]  ref_x, ref_sy, ref_ty;

  typedef struct { int id; int func; int data; int cyc; } exp_t;
  exp_t sb[$];
  int st_x[$], st_f[$], st_e[$];
  int n_cmp = 0, n_err = 0, cyc = 0;

  lstm_act_scheduler #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_func(req_func), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_func(out_func),
    .busy(busy), .done_cnt(done_cnt)
  );

  sigmoid_q6_11 #(.WIDTH(W)) u_ref_s (.x(ref_x), .y(ref_sy));
  tanh_q6_11    #(.WIDTH(W)) u_ref_t (.x(ref_x), .y(ref_ty));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every counted output transfer.
  always @(negedge clk) begin
    if (out_valid && out_ready && !flush && !rst) begin
      if (sb.size() == 0) begin
        chk("extra_output", int'(out_id), -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_id", int'(out_id), e.id);
        chk("out_func", int'(out_func), e.func);
        chk("out_data", int'($signed(out_data)), e.data);
        if (e.cyc >= 0) chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic push(input int id, input int f, input int d, input int c);
    exp_t e;
    e.id = id; e.func = f; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_req(input int k, input int x, input int f);
    req_data[k*W +: W] = W'(x);
    req_func[k] = f[0];
  endtask

  // Feed st_* through requester k one item per accept.
  task automatic stream(input int k, input bit lat);
    for (int i = 0; i < st_x.size(); i++) begin
      int t;
      set_req(k, st_x[i], st_f[i]);
      req_valid[k] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!req_ready[k] && t < 60);
      if (!req_ready[k]) chk("accept_timeout", 0, 1);
      push(k, st_f[i], st_e[i], lat ? cyc + 2 : -1);
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
    chk("idle_after_drain", int'(out_valid), 0);
    @(posedge clk); #1;
  endtask

  // Load 3 requesters with out_ready low until both stages are full.
  task automatic fill_full();
    out_ready = 1'b0;
    set_req(0, 2048, 0);
    set_req(1, 1024, 1);
    set_req(3, -2048, 0);
    req_valid = 4'b1011;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("full_ready", int'(req_ready), 0);
    chk("full_busy", int'(busy), 1);
    chk("full_out_id", int'(out_id), 3);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    req_valid = '1; req_func = '0; req_data = '0; ref_x = '0;

    // Reset with everyone requesting.
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_done_cnt", int'(done_cnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_data", int'(out_data), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;

    // Single requests with latency check.
    st_x = {0}; st_f = {0}; st_e = {1024};
    stream(2, 1'b1);
    st_x = {0}; st_f = {1}; st_e = {0};
    stream(1, 1'b1);
    drain();
    chk("done_after_single", int'(done_cnt), 2);

    // Round-robin from ptr 0 after reset.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    set_req(0, 2048, 0);
    set_req(1, 1024, 1);
    set_req(2, -2048, 0);
    set_req(3, 2048, 1);
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      int rr_e[4] = '{1536, 1024, 512, 1536};
      @(negedge clk);
      chk("rr_grant", int'(req_ready), 1 << (i % 4));
      push(i % 4, i % 2, rr_e[i % 4], cyc + 2);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();
    chk("rr_done_cnt", int'(done_cnt), 8);

    // Backpressure: 6-item stream with a 5-cycle stall.
    st_x = {0, 2048, -2048, -1024, 4096, 8192};
    st_f = {0, 1, 0, 1, 0, 1};
    st_e = {1024, 1536, 512, -1024, 1792, 2048};
    fork
      stream(0, 1'b0);
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid && t < 60);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_valid", int'(out_valid), 1);
          if (sb.size() > 0) begin
            chk("stall_id", int'(out_id), sb[0].id);
            chk("stall_func", int'(out_func), sb[0].func);
            chk("stall_data", int'($signed(out_data)), sb[0].data);
          end
          if (s >= 1) chk("stall_req_ready", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_done_cnt", int'(done_cnt), 14);

    // Bit-exactness sweep against reference units.
    st_x.delete(); st_f.delete(); st_e.delete();
    for (int i = 0; i < 512; i++) begin
      int x;
      x = -16384 + 64 * i;
      ref_x = W'(x);
      #1;
      st_x.push_back(x);
      st_f.push_back(i % 2);
      st_e.push_back((i % 2) ? int'($signed(ref_ty)) : int'($signed(ref_sy)));
    end
    @(posedge clk); #1;
    stream(1, 1'b0);
    drain();
    chk("sweep_done_cnt", int'(done_cnt), 526);

    // Flush with both stages full; flush overrides a concurrent out_ready.
    fill_full();
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_req_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_done_cnt", int'(done_cnt), 526);
    chk("flush_next_grant", int'(req_ready), 4'b0010);
    push(1, 1, 1024, cyc + 2);
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    chk("flush_done_after", int'(done_cnt), 527);

    // Reset with both stages full.
    fill_full();
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_req_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_done_cnt", int'(done_cnt), 0);
    chk("rst2_next_grant", int'(req_ready), 4'b0001);
    push(0, 0, 1536, cyc + 2);
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    chk("rst2_done_after", int'(done_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lstm_act_scheduler.md
# lstm_act_scheduler

Shares one sigmoid unit and one tanh unit among `NREQ` LSTM gate requesters (typically i, f, g, o) in Q6.11 fixed point. Each requester presents a pre-activation value with a function select. The block arbitrates round-robin, runs the selected activation in a 2-stage pipeline with full valid/ready backpressure, and returns a result tagged with requester ID and function. It sits between the gate MAC outputs and the cell-state update logic.

## Interface
- `WIDTH`, 18: data width, signed Q6.11 (1.0 = 2048).
- `NREQ`, 4: number of requesters; must be 2..8.
- `IDW`, 2: ID width; must satisfy 2^IDW >= NREQ.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous pipeline clear.
- `req_valid` input NREQ: per-requester valid.
- `req_func` input NREQ: per-requester function select; 0 = sigmoid, 1 = tanh.
- `req_data` input NREQ*WIDTH: per-requester x, requester k at bits [k*WIDTH +: WIDTH].
- `req_ready` output NREQ: one-hot-or-zero accept.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accept.
- `out_data` output WIDTH: activation result, signed Q6.11.
- `out_id` output IDW: index of the originating requester.
- `out_func` output 1: function used.
- `busy` output 1: any pipeline stage holds valid data.
- `done_cnt` output 16: count of completed output transfers; wraps modulo 2^16.

## Operation
- Instantiates one `sigmoid_q6_11` and one `tanh_q6_11` (both combinational, x→y).
- Stage 1 (S1) registers x, ID and func of the granted request.
- Stage 2 (S2) registers y from the unit selected by S1 func, plus ID and func. S2 drives the `out_*` ports directly.
- Advance rules:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
- Arbitration: when adv1 = 1, grant the first k with req_valid[k] = 1, searching from pointer `ptr` upward modulo NREQ.
  - req_ready[k] = adv1 & grant[k]. This is combinational and may depend on `out_ready`.
  - Requesters must hold data and func stable while valid and not ready.
- Pointer update: on an accepted request from k, `ptr` <= (k+1) mod NREQ. With no accept, `ptr` holds.
- Output transfer: out_valid & out_ready. Each transfer increments `done_cnt`.
- Data transport is bit-exact. `out_data` equals the selected unit's output for the accepted x, with no rounding or saturation added.
- `flush`: clears s1_valid and s2_valid. `ptr` and `done_cnt` are unchanged. While flush = 1, req_ready = 0.
- If `flush` and `out_ready` are both high in the same cycle, the transfer is not counted; flush wins.
- Reset values: s1_valid = 0, s2_valid = 0, ptr = 0, done_cnt = 0. All data, ID and func registers = 0.
- Output values during reset: out_valid = 0, busy = 0, req_ready = 0, out_data = 0, out_id = 0, out_func = 0.
- Reset mid-operation: in-flight results are discarded and never appear on the output.

## Timing
- Latency: a request accepted at edge N is in S1 after N and in S2 after N+1. out_valid is high in the cycle after edge N+1 (2 cycles, accept to output).
- Throughput: one result per cycle when out_ready is held high.
- Backpressure: with out_ready = 0, S2 holds its values and S1 fills.
  - After that, req_ready = 0 for all requesters.
  - At most 2 results are buffered; nothing is dropped or duplicated.
- Output stability: out_data, out_id and out_func are stable while out_valid & !out_ready.
- A single requester holding valid continuously is granted every cycle. The pointer still advances, but the other requesters are idle.
- Simultaneous requests: all NREQ valid from ptr = 0 gives grants in order 0, 1, 2, 3, 0, …
- `busy` is registered-derived: busy = s1_valid | s2_valid.

## Test plan
- Reset/idle: assert rst for 3 cycles with all requesters active. Required: req_ready = 0, out_valid = 0, done_cnt = 0, busy = 0 throughout.
- Single requests: req 2 sends x = 0 with sigmoid, then req 1 sends x = 0 with tanh. Required: out_data = 1024 with out_id = 2, then out_data = 0 with out_id = 1. Each result appears 2 cycles after its accept.
- Round-robin: all 4 requesters valid continuously with out_ready = 1. Required: accepts and results come in ID order 0, 1, 2, 3, 0, 1, …; one result per cycle; done_cnt = 8 after 8 transfers.
- Backpressure: stream 6 requests and drop out_ready for 5 cycles mid-stream. Required:
  - out_* hold stable during the stall.
  - req_ready = 0 once both stages are full.
  - All 6 results appear in order with no loss or duplication.
- Bit-exactness sweep: sweep x from -16384 to +16383 in steps of 64, alternating func. Required: each out_data equals a directly instantiated sigmoid_q6_11 or tanh_q6_11 fed the same x.
- Flush and reset mid-flight: with both stages full, assert flush for 1 cycle. Required:
  - out_valid = 0 next cycle; done_cnt and ptr unchanged.
  - The next grant continues from the held ptr.
  - Repeat with rst instead: ptr = 0 and done_cnt = 0 afterwards.
